// File: rtl/reg_file_wb_sink_if.sv
// Write-back bus between the WB stage (master) and the register file (slave).
//   wb_addr : destination register index
//   wb_en   : write enable, already qualified by the WB stage's valid
//   wb_data : value to write
interface reg_file_wb_sink_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

    modport master (output wb_addr, output wb_en, output wb_data);
    modport slave  (input  wb_addr, input  wb_en, input  wb_data);
endinterface

// File: rtl/reg_file_wb_sink.sv
// Architectural register file, sink end of the write-back interface.
// One write port (wb, slave modport), three combinational read ports with
// write-through bypass. Index NUM_REGS-1 aliases the PC: reads return pc_val_i,
// writes are dropped.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb                    write-back bus (addr/en/data)
//   rd_addr_{a,b,c}_i     read addresses (Rn, Rm, store-data Rd)
//   pc_val_i              value returned for index NUM_REGS-1
//   rd_data_{a,b,c}_o     read data
//   iss_en_i, iss_addr_i  issue of an instr with a register destination
//   rd_use_i              per-port use bits {c,b,a} of the instr in decode
//   stall_o, pend_cnt_o   decode stall and number of pending registers
// Optional feature: define REG_FILE_SCOREBOARD_EN to build the in-flight
// destination scoreboard; otherwise stall_o and pend_cnt_o are tied to 0.
module reg_file_wb_sink #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    localparam int unsigned NUM_REGS = 2 ** ADDR_W,
    localparam int unsigned CNT_W = $clog2(NUM_REGS) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_file_wb_sink_if.slave  wb,
    input  logic [ADDR_W-1:0]  rd_addr_a_i,
    input  logic [ADDR_W-1:0]  rd_addr_b_i,
    input  logic [ADDR_W-1:0]  rd_addr_c_i,
    input  logic [DATA_W-1:0]  pc_val_i,
    output logic [DATA_W-1:0]  rd_data_a_o,
    output logic [DATA_W-1:0]  rd_data_b_o,
    output logic [DATA_W-1:0]  rd_data_c_o,
    input  logic               iss_en_i,
    input  logic [ADDR_W-1:0]  iss_addr_i,
    input  logic [2:0]         rd_use_i,
    output logic               stall_o,
    output logic [CNT_W-1:0]   pend_cnt_o
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];
    logic [2:0]        wb_hit;

    // Register bank: only the write port updates it; PC alias writes are dropped.
    always_comb begin
        regs_d = regs_q;
        if (wb.wb_en && (wb.wb_addr != PC_IDX)) begin
            regs_d[wb.wb_addr] = wb.wb_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: PC alias first, then same-cycle bypass, then the bank.
    // Not gated by reset, so bypass stays visible while rst_i is high.
    always_comb begin
        rd_addr[0] = rd_addr_a_i;
        rd_addr[1] = rd_addr_b_i;
        rd_addr[2] = rd_addr_c_i;
        wb_hit     = '0;
        for (int p = 0; p < 3; p++) begin
            wb_hit[p] = wb.wb_en && (wb.wb_addr == rd_addr[p]);
            if (rd_addr[p] == PC_IDX) begin
                rd_data[p] = pc_val_i;
            end else if (wb_hit[p]) begin
                rd_data[p] = wb.wb_data;
            end else begin
                rd_data[p] = regs_q[rd_addr[p]];
            end
        end
    end

    assign rd_data_a_o = rd_data[0];
    assign rd_data_b_o = rd_data[1];
    assign rd_data_c_o = rd_data[2];

`ifdef REG_FILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stall;

    // A write-back landing this cycle resolves the hazard via the bypass.
    always_comb begin
        stall = 1'b0;
        for (int p = 0; p < 3; p++) begin
            stall = stall | (rd_use_i[p] & pend_q[rd_addr[p]] & ~wb_hit[p]);
        end
    end

    // Clear before set so a same-index issue (newer producer) wins.
    always_comb begin
        pend_d = pend_q;
        if (wb.wb_en) begin
            pend_d[wb.wb_addr] = 1'b0;
        end
        if (iss_en_i && !stall && (iss_addr_i != PC_IDX)) begin
            pend_d[iss_addr_i] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_o    = stall;
    assign pend_cnt_o = cnt_q;
`else
    logic unused_sb;
    assign unused_sb  = ^{iss_en_i, iss_addr_i, rd_use_i};
    assign stall_o    = 1'b0;
    assign pend_cnt_o = '0;
`endif

endmodule
